layer_pingpong_buf: RTL and testbench
=====================================

LAYER_PINGPONG_BUF -- requirements
Module: layer_pingpong_buf

Interface
REQ-001 SHALL have parameter DW, default 18, data word width in bits.
REQ-002 SHALL have parameter AW, default 14, per-bank address width.
REQ-003 SHALL have parameter DEPTH, default 16384, words per bank; DEPTH <= 2^AW.
REQ-004 SHALL have parameter NBANK, default 2, bank count; NBANK >= 2, power of two.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port wr_en, input, 1, write strobe from the producing layer.
REQ-008 SHALL have port wr_addr, input, AW, word address within the current write bank.
REQ-009 SHALL have port wr_data, input, DW, write data.
REQ-010 SHALL have port wr_done, input, 1, single-cycle pulse: producer has finished the current write bank.
REQ-011 SHALL have port wr_ready, output, 1, high when a bank is free for writing.
REQ-012 SHALL have port rd_en, input, 1, read strobe from the consuming layer.
REQ-013 SHALL have port rd_addr, input, AW, word address within the current read bank.
REQ-014 SHALL have port rd_done, input, 1, single-cycle pulse: consumer has released the current read bank.
REQ-015 SHALL have port rd_ready, output, 1, high when a full bank is available for reading.
REQ-016 SHALL have port rd_data, output, DW, read data.
REQ-017 SHALL have port rd_valid, output, 1, rd_data qualifier.
REQ-018 SHALL have port full_cnt, output, log2(NBANK)+1, number of full banks.
REQ-019 SHALL have port err, output, 1, sticky protocol-error flag.

Function
REQ-020 SHALL keep write-bank pointer wbank, read-bank pointer rbank (mod NBANK) and full_cnt (0..NBANK).
REQ-021 SHALL drive wr_ready = (full_cnt < NBANK) and rd_ready = (full_cnt > 0), combinationally from registers.
REQ-022 SHALL write wr_data to physical word wbank*DEPTH + wr_addr when wr_en && wr_ready && wr_addr < DEPTH.
REQ-023 SHALL, on wr_done && wr_ready, advance wbank by 1 (wrapping NBANK-1 -> 0) and increment full_cnt.
REQ-024 SHALL, on rd_done && rd_ready, advance rbank by 1 (wrapping) and decrement full_cnt.
REQ-025 SHALL, on simultaneous accepted wr_done and rd_done, advance both pointers and leave full_cnt unchanged.
REQ-026 SHALL, on rd_en && rd_ready && rd_addr < DEPTH, present word rbank*DEPTH + rd_addr on rd_data exactly 1 cycle later, with rd_valid high for that cycle only.
REQ-027 SHALL hold rd_data at its last value while rd_valid is low.
REQ-028 SHALL never read a bank from which a write is possible: the read bank is always full and the write bank never full, so no read/write collision occurs.
REQ-029 SHALL ignore, and set err on, any of the following: wr_en or wr_done while !wr_ready; rd_en or rd_done while !rd_ready; wr_en/rd_en with address >= DEPTH.
REQ-030 SHALL keep err set until reset.
REQ-031 SHALL accept back-to-back writes or reads every cycle, with no bubbles.

Reset
REQ-032 SHALL, while rst_n is low, force wbank=0, rbank=0, full_cnt=0, rd_valid=0, rd_data=0 and err=0, giving wr_ready=1 and rd_ready=0.
REQ-033 SHALL, on reset mid-operation, discard all bank state; RAM contents are not cleared and are undefined to the reader until rewritten.
REQ-034 SHALL abort an in-flight read on reset; rd_valid is 0 in the first cycle after release.

Structure
REQ-035 SHALL take shared defaults (DW, AW, DEPTH, NBANK) from the project package layer_buf_pkg, alongside the bank-state width function clog2.
REQ-036 SHALL instantiate one sub-module, layer_buf_sdpram: an inferred simple dual-port RAM of NBANK*DEPTH x DW with one write port, one registered read port and no reset on storage.
REQ-037 SHALL place all pointer, counter, handshake and error logic in layer_pingpong_buf.

Verification
REQ-038 SHALL test fill/drain: write 0..15 to addr 0..15, pulse wr_done -> full_cnt=1, rd_ready=1; read addr 5 -> rd_data=5 one cycle later, rd_valid pulse.
REQ-039 SHALL test ping-pong overlap (NBANK=2): fill bank0, then fill bank1 with 100+i while reading bank0 -> bank0 returns i, and after rd_done bank1 returns 100+i.
REQ-040 SHALL test full: two wr_done with no rd_done -> wr_ready=0; a further wr_en/wr_done -> ignored, err=1, full_cnt stays 2.
REQ-041 SHALL test simultaneous events: with full_cnt=1, pulse wr_done and rd_done in the same cycle -> full_cnt=1, wbank and rbank both advance, and wrap 1->0.
REQ-042 SHALL test out-of-range and empty errors: rd_en at reset -> no rd_valid, err=1; with DEPTH=10, wr_addr=12 -> no write, err=1.
REQ-043 SHALL test reset mid-transfer: assert rst_n low during a read burst -> rd_valid=0, full_cnt=0, wr_ready=1 and err=0 immediately, asynchronously.

Source files
------------

// File: rtl/layer_buf_pkg.sv
// Shared defaults and helpers for the layer ping-pong buffer.
package layer_buf_pkg;

   localparam int unsigned DEF_DW    = 18;
   localparam int unsigned DEF_AW    = 14;
   localparam int unsigned DEF_DEPTH = 16384;
   localparam int unsigned DEF_NBANK = 2;

   // Ceiling log2; returns 0 for inputs of 0 or 1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'(1) << i) < 64'(v)) r = 32'(i + 1);
      end
      return r;
   endfunction

endpackage

// File: rtl/layer_buf_sdpram.sv
// Simple dual-port RAM: one write port, one registered read port.
module layer_buf_sdpram
   import layer_buf_pkg::*;
#(
   parameter int unsigned DW    = DEF_DW,
   parameter int unsigned WORDS = DEF_NBANK * DEF_DEPTH,
   parameter int unsigned PAW   = clog2(DEF_NBANK * DEF_DEPTH)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           we,
   input  logic [PAW-1:0] waddr,
   input  logic [DW-1:0]  wdata,
   input  logic           re,
   input  logic [PAW-1:0] raddr,
   output logic [DW-1:0]  rdata
);

   logic [DW-1:0] mem [WORDS];

   // Storage is deliberately not reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Output register holds its value between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/layer_pingpong_buf.sv
// Multi-bank ping-pong buffer between a producing and a consuming layer.
module layer_pingpong_buf
   import layer_buf_pkg::*;
#(
   parameter int unsigned DW    = DEF_DW,
   parameter int unsigned AW    = DEF_AW,
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned NBANK = DEF_NBANK
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [DW-1:0]         wr_data,
   input  logic                  wr_done,
   output logic                  wr_ready,
   input  logic                  rd_en,
   input  logic [AW-1:0]         rd_addr,
   input  logic                  rd_done,
   output logic                  rd_ready,
   output logic [DW-1:0]         rd_data,
   output logic                  rd_valid,
   output logic [clog2(NBANK):0] full_cnt,
   output logic                  err
);

   localparam int unsigned BW    = clog2(NBANK);
   localparam int unsigned CW    = BW + 1;
   localparam int unsigned WORDS = NBANK * DEPTH;
   localparam int unsigned PAW   = clog2(WORDS);

   logic [BW-1:0]  wbank, wbank_d, rbank, rbank_d;
   logic [CW-1:0]  full_d;
   logic           err_d, rd_valid_d;
   logic           wr_acc, wd_acc, rd_acc, rdd_acc, err_evt;
   logic [PAW-1:0] waddr_phys, raddr_phys;

   // The write bank is never full and the read bank always full, so they never coincide.
   assign wr_ready = (full_cnt < CW'(NBANK));
   assign rd_ready = (full_cnt != '0);

   always_comb begin
      wr_acc     = wr_en && wr_ready && (32'(wr_addr) < DEPTH);
      wd_acc     = wr_done && wr_ready;
      rd_acc     = rd_en && rd_ready && (32'(rd_addr) < DEPTH);
      rdd_acc    = rd_done && rd_ready;
      err_evt    = (wr_en && !wr_acc) || (wr_done && !wr_ready) ||
                   (rd_en && !rd_acc) || (rd_done && !rd_ready);
      wbank_d    = wbank + BW'(wd_acc);
      rbank_d    = rbank + BW'(rdd_acc);
      full_d     = full_cnt;
      if (wd_acc && !rdd_acc)      full_d = full_cnt + CW'(1);
      else if (!wd_acc && rdd_acc) full_d = full_cnt - CW'(1);
      err_d      = err | err_evt;
      rd_valid_d = rd_acc;
      waddr_phys = PAW'(32'(wbank) * DEPTH + 32'(wr_addr));
      raddr_phys = PAW'(32'(rbank) * DEPTH + 32'(rd_addr));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbank    <= '0;
         rbank    <= '0;
         full_cnt <= '0;
         err      <= 1'b0;
         rd_valid <= 1'b0;
      end else begin
         wbank    <= wbank_d;
         rbank    <= rbank_d;
         full_cnt <= full_d;
         err      <= err_d;
         rd_valid <= rd_valid_d;
      end
   end

   layer_buf_sdpram #(
      .DW    (DW),
      .WORDS (WORDS),
      .PAW   (PAW)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_acc),
      .waddr (waddr_phys),
      .wdata (wr_data),
      .re    (rd_acc),
      .raddr (raddr_phys),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_layer_pingpong_buf.sv
// Directed bench for layer_pingpong_buf with a bank-level reference model.
module tb_layer_pingpong_buf;

   localparam int unsigned DW = 18, AW = 5, DEPTH = 16, NBANK = 2;
   localparam int unsigned SAW = 4, SDEPTH = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0, s_rst_n = 1'b0;

   logic          wr_en = 0, wr_done = 0, rd_en = 0, rd_done = 0;
   logic [AW-1:0] wr_addr = '0, rd_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_ready, rd_ready, rd_valid, err;
   logic [DW-1:0] rd_data;
   logic [1:0]    full_cnt;

   logic           s_wr_en = 0, s_wr_done = 0, s_rd_en = 0, s_rd_done = 0;
   logic [SAW-1:0] s_wr_addr = '0, s_rd_addr = '0;
   logic [DW-1:0]  s_wr_data = '0;
   logic           s_wr_ready, s_rd_ready, s_rd_valid, s_err;
   logic [DW-1:0]  s_rd_data;
   logic [1:0]     s_full_cnt;

   int n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   layer_pingpong_buf #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .NBANK(NBANK)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done), .wr_ready(wr_ready),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done), .rd_ready(rd_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .full_cnt(full_cnt), .err(err)
   );

   layer_pingpong_buf #(.DW(DW), .AW(SAW), .DEPTH(SDEPTH), .NBANK(NBANK)) dut_small (
      .clk(clk), .rst_n(s_rst_n),
      .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_done(s_wr_done),
      .wr_ready(s_wr_ready), .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_done(s_rd_done),
      .rd_ready(s_rd_ready), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
      .full_cnt(s_full_cnt), .err(s_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Bank-level reference model: banks form a ring, occupancy is a plain count.
   int  m_mem [NBANK*DEPTH];
   bit  m_known [NBANK*DEPTH];
   int  m_wb = 0, m_rb = 0, m_full = 0, m_data = 0, m_idx;
   bit  m_err = 0, m_valid = 0, m_dknown = 1, m_wrdy, m_rrdy;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_wb = 0; m_rb = 0; m_full = 0; m_err = 0;
         m_valid = 0; m_data = 0; m_dknown = 1;
         foreach (m_known[i]) m_known[i] = 0;
      end else begin
         m_wrdy  = (m_full < NBANK);
         m_rrdy  = (m_full > 0);
         m_valid = 0;
         if (rd_en) begin
            if (m_rrdy && rd_addr < DEPTH) begin
               m_idx    = m_rb * DEPTH + int'(rd_addr);
               m_valid  = 1;
               m_data   = m_mem[m_idx];
               m_dknown = m_known[m_idx];
            end else m_err = 1;
         end
         if (wr_en) begin
            if (m_wrdy && wr_addr < DEPTH) begin
               m_idx          = m_wb * DEPTH + int'(wr_addr);
               m_mem[m_idx]   = int'(wr_data);
               m_known[m_idx] = 1;
            end else m_err = 1;
         end
         if (wr_done && !m_wrdy) m_err = 1;
         if (rd_done && !m_rrdy) m_err = 1;
         if (wr_done && m_wrdy) begin m_wb = (m_wb + 1) % NBANK; m_full++; end
         if (rd_done && m_rrdy) begin m_rb = (m_rb + 1) % NBANK; m_full--; end
      end
   end

   always @(negedge clk) begin
      check("full_cnt", 32'(full_cnt), m_full);
      check("wr_ready", 32'(wr_ready), 32'(m_full < NBANK));
      check("rd_ready", 32'(rd_ready), 32'(m_full > 0));
      check("err", 32'(err), 32'(m_err));
      check("rd_valid", 32'(rd_valid), 32'(m_valid));
      if (m_dknown) check("rd_data", 32'(rd_data), m_data);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) cyc();
      check("rst_full", 32'(full_cnt), 0);
      check("rst_wr_ready", 32'(wr_ready), 1);
      check("rst_rd_ready", 32'(rd_ready), 0);
      check("rst_err", 32'(err), 0);
      check("rst_rd_valid", 32'(rd_valid), 0);
      check("rst_rd_data", 32'(rd_data), 0);
      rst_n = 1'b1;
      cyc();

      // Fill bank 0 and read one word back.
      for (int i = 0; i < 16; i++) begin
         wr_en = 1; wr_addr = AW'(i); wr_data = DW'(i);
         cyc();
      end
      wr_en = 0; wr_done = 1; cyc(); wr_done = 0;
      check("fill_full", 32'(full_cnt), 1);
      check("fill_rd_ready", 32'(rd_ready), 1);
      rd_en = 1; rd_addr = 5; cyc(); rd_en = 0;
      check("rd5_valid", 32'(rd_valid), 1);
      check("rd5_data", 32'(rd_data), 5);
      cyc();
      check("rd5_valid_drop", 32'(rd_valid), 0);
      check("rd5_hold", 32'(rd_data), 5);

      // Fill bank 1 while draining bank 0 in the same cycles.
      for (int i = 0; i < 16; i++) begin
         wr_en = 1; wr_addr = AW'(i); wr_data = DW'(100 + i);
         rd_en = 1; rd_addr = AW'(i);
         cyc();
         if (i == 9) check("pp_bank0", 32'(rd_data), 9);
      end
      wr_en = 0; rd_en = 0;
      wr_done = 1; cyc(); wr_done = 0;
      check("full2_cnt", 32'(full_cnt), 2);
      check("full2_wr_ready", 32'(wr_ready), 0);

      // Writes while full are dropped and flagged.
      wr_en = 1; wr_addr = 0; wr_data = DW'(999); cyc(); wr_en = 0;
      check("full_wr_err", 32'(err), 1);
      wr_done = 1; cyc(); wr_done = 0;
      check("full_done_cnt", 32'(full_cnt), 2);
      rd_en = 1; rd_addr = 0; cyc(); rd_en = 0;
      check("full_no_write", 32'(rd_data), 0);
      rd_done = 1; cyc(); rd_done = 0;
      check("release_cnt", 32'(full_cnt), 1);
      for (int i = 0; i < 16; i++) begin
         rd_en = 1; rd_addr = AW'(i); cyc();
         if (i == 3) check("pp_bank1", 32'(rd_data), 103);
      end
      rd_en = 0;

      // Simultaneous done pulses: count steady, both pointers advance and wrap.
      for (int i = 0; i < 4; i++) begin
         wr_en = 1; wr_addr = AW'(i); wr_data = DW'(200 + i); cyc();
      end
      wr_en = 0; wr_done = 1; rd_done = 1; cyc(); wr_done = 0; rd_done = 0;
      check("sim1_cnt", 32'(full_cnt), 1);
      rd_en = 1; rd_addr = 2; cyc(); rd_en = 0;
      check("sim1_rbank_wrap", 32'(rd_data), 202);
      wr_en = 1; wr_addr = 0; wr_data = DW'(300); cyc(); wr_en = 0;
      wr_done = 1; rd_done = 1; cyc(); wr_done = 0; rd_done = 0;
      check("sim2_cnt", 32'(full_cnt), 1);
      rd_en = 1; rd_addr = 0; cyc(); rd_en = 0;
      check("sim2_data", 32'(rd_data), 300);
      wr_en = 1; wr_addr = 0; wr_data = DW'(400); cyc(); wr_en = 0;
      wr_done = 1; cyc(); wr_done = 0;
      rd_done = 1; cyc(); rd_done = 0;
      rd_en = 1; rd_addr = 0; cyc(); rd_en = 0;
      check("sim_wbank_wrap", 32'(rd_data), 400);

      // Asynchronous reset in the middle of a read burst.
      for (int i = 0; i < 3; i++) begin
         rd_en = 1; rd_addr = AW'(i); cyc();
      end
      #2 rst_n = 1'b0; rd_en = 0;
      #1;
      check("arst_rd_valid", 32'(rd_valid), 0);
      check("arst_full", 32'(full_cnt), 0);
      check("arst_wr_ready", 32'(wr_ready), 1);
      check("arst_err", 32'(err), 0);
      cyc();
      rst_n = 1'b1;
      cyc();
      check("arst_post_valid", 32'(rd_valid), 0);
      check("arst_post_data", 32'(rd_data), 0);

      // Small instance, DEPTH=10: empty read and out-of-range write.
      s_rst_n = 1'b1; cyc();
      s_rd_en = 1; s_rd_addr = 0; cyc(); s_rd_en = 0;
      check("s_empty_valid", 32'(s_rd_valid), 0);
      check("s_empty_err", 32'(s_err), 1);
      s_rst_n = 1'b0; cyc(); s_rst_n = 1'b1; cyc();
      check("s_err_cleared", 32'(s_err), 0);
      s_wr_done = 1; cyc(); s_wr_done = 0;
      s_wr_en = 1; s_wr_addr = 2; s_wr_data = DW'(33); cyc(); s_wr_en = 0;
      s_wr_done = 1; cyc(); s_wr_done = 0;
      s_rd_done = 1; cyc(); s_rd_done = 0;
      check("s_full", 32'(s_full_cnt), 1);
      check("s_err_clean", 32'(s_err), 0);
      s_wr_en = 1; s_wr_addr = 12; s_wr_data = DW'(170); cyc(); s_wr_en = 0;
      check("s_oor_err", 32'(s_err), 1);
      s_rd_en = 1; s_rd_addr = 2; cyc(); s_rd_en = 0;
      check("s_oor_valid", 32'(s_rd_valid), 1);
      check("s_oor_no_write", 32'(s_rd_data), 33);

      cyc();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
